// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter with a registered one-hot grant,
// a registered binary index, and a bounded hold time per grant.
module rr_onehot_arbiter #(
   parameter int N        = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N-1:0]     i_req,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_grant_idx,
   output logic             o_grant_valid,
   output logic             o_timeout
);

   localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);
   localparam logic [N-1:0]     ONE     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] LAST    = IDX_W'(N - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]       r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [N-1:0]     r_grant;
   logic [IDX_W-1:0] r_grant_idx;
   logic             r_timeout;

   logic [IDX_W-1:0] w_next;
   logic [IDX_W-1:0] w_start;
   logic             w_cur_req;
   logic             w_release;
   logic             w_expire;
   logic             w_found;
   logic [IDX_W-1:0] w_win;

   // First set request scanning start, start+1, ... with wrap at N.
   function automatic logic [IDX_W:0] f_pick(input logic [N-1:0] req,
                                             input logic [IDX_W-1:0] start);
      logic             found;
      logic [IDX_W-1:0] win;
      logic [N-1:0]     sh;
      int               idx;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(start) + k;
         if (idx >= N) idx = idx - N;
         sh = req >> idx;
         if (!found && sh[0]) begin
            found = 1'b1;
            win   = IDX_W'(idx);
         end
      end
      return {found, win};
   endfunction

   // Next pointer wraps explicitly so N < 2**IDX_W never reaches an illegal index.
   assign w_next    = (r_grant_idx == LAST) ? '0 : r_grant_idx + IDX_W'(1);
   // Current holder still requesting; grant is one-hot so a mask avoids indexing.
   assign w_cur_req = |(i_req & r_grant);
   assign w_release = (r_state == GRANT) && !w_cur_req;
   assign w_expire  = (r_state == GRANT) && w_cur_req && (r_hold_cnt == CNT_MAX);
   // Same-edge re-arbitration scans from just past the outgoing grantee.
   assign w_start   = (r_state == IDLE) ? r_ptr : w_next;
   assign {w_found, w_win} = f_pick(i_req, w_start);

   // Arbitration FSM: grant, hold counting, release/expire hand-off.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_hold_cnt  <= '0;
         r_grant     <= '0;
         r_grant_idx <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant     <= ONE << w_win;
                  r_grant_idx <= w_win;
                  r_hold_cnt  <= '0;
                  r_state     <= GRANT;
               end
            end
            GRANT: begin
               if (w_release || w_expire) begin
                  r_ptr     <= w_next;
                  // Release wins over a coincident expire: no pulse then.
                  r_timeout <= w_expire;
                  if (w_found) begin
                     r_grant     <= ONE << w_win;
                     r_grant_idx <= w_win;
                     r_hold_cnt  <= '0;
                  end else begin
                     r_grant <= '0;
                     r_state <= IDLE;
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_grant <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_grant       = r_grant;
   assign o_grant_idx   = r_grant_idx;
   assign o_grant_valid = |r_grant;
   assign o_timeout     = r_timeout;

endmodule
